// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared types and constants for the writeback arbiter and register file
package regfile_wb_arbiter_pkg;
  typedef enum logic {NORMAL = 1'b0, STARVE = 1'b1} wb_state_e;
  localparam int REG_ZERO = 0;
  localparam int DEFAULT_DATA_BITS = 32;
  localparam int DEFAULT_ADDR_BITS = 5;
endpackage

// File: rtl/regfile_wb_starve_counter.sv
// wb_starve_counter: counts consecutive refusals of port 1 and forces its priority after MAX_WAIT
module wb_starve_counter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req1_valid,
  input  logic req1_ready,
  output logic starve,
  output logic starve_next
);
  logic [3:0] wait_cnt_d, wait_cnt_q;
  wb_state_e  state_d, state_q;
  logic       refused;
  assign refused = req1_valid && !req1_ready;
  // A refused cycle bumps the count (saturating); a transfer or withdrawal clears it and leaves STARVE
  always_comb begin
    wait_cnt_d = refused ? ((wait_cnt_q == 4'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 4'd1) : 4'd0;
    state_d    = (state_q == NORMAL) ? ((wait_cnt_d == 4'(MAX_WAIT)) ? STARVE : NORMAL)
                                     : (refused ? STARVE : NORMAL);
  end
  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      state_q    <= NORMAL;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      state_q    <= state_d;
    end
  end
  assign starve      = state_q == STARVE;
  assign starve_next = state_d == STARVE;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between pipeline and multi-cycle writeback
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int ADDR_BITS = DEFAULT_ADDR_BITS,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic [ADDR_BITS-1:0] req0_addr,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_BITS-1:0] req1_addr,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 WriteEnable,
  output logic [ADDR_BITS-1:0] DAddress,
  output logic [DATA_BITS-1:0] DData,
  output logic                 starve
);
  logic                 go0, go1, starve_next;
  logic                 write_enable_d, write_enable_q;
  logic [ADDR_BITS-1:0] d_address_d, d_address_q;
  logic [DATA_BITS-1:0] d_data_d, d_data_q;
  wb_starve_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk        (clk),
    .rst        (rst),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .starve     (starve),
    .starve_next(starve_next)
  );
  assign req0_ready = !rst && req0_valid && !(starve && req1_valid);
  assign req1_ready = !rst && req1_valid && !(!starve && req0_valid);
  assign go0 = req0_valid && req0_ready;
  assign go1 = req1_valid && req1_ready;
  // Load the winner into the write port; r0 writes are accepted but never enabled
  always_comb begin
    write_enable_d = go0 ? (req0_addr != ADDR_BITS'(REG_ZERO)) : go1 ? (req1_addr != ADDR_BITS'(REG_ZERO)) : 1'b0;
    d_address_d    = go0 ? req0_addr : go1 ? req1_addr : d_address_q;
    d_data_d       = go0 ? req0_data : go1 ? req1_data : d_data_q;
  end
  // Registered write port feeding the register file directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable_q <= 1'b0;
      d_address_q    <= '0;
      d_data_q       <= '0;
    end else begin
      write_enable_q <= write_enable_d;
      d_address_q    <= d_address_d;
      d_data_q       <= d_data_d;
    end
  end
  assign WriteEnable = write_enable_q;
  assign DAddress    = d_address_q;
  assign DData       = d_data_q;
  // STARVE can only be entered or held while port 1 is actually asking
  a_starve_needs_req1: assert property (@(posedge clk) disable iff (rst) starve_next |-> req1_valid);
endmodule
